// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage that issues sequential word fetches,
//               buffers in-order responses in a skid FIFO and feeds id_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      fifo_pc  [FIFO_DEPTH];
    logic [31:0]      fifo_ins [FIFO_DEPTH];
    logic [31:0]      hold_pc;
    logic [31:0]      hold_ins;

    logic [CNT_W:0]   in_use;
    logic [31:0]      target_pc;
    logic             credit_ok;
    logic             req_fire;
    logic             drop;
    logic             push;
    logic             pop;
    logic             head_valid;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        in_use     = {1'b0, outstanding} + {1'b0, fifo_count};
        credit_ok  = in_use < (CNT_W + 1)'(FIFO_DEPTH);
        target_pc  = redirect_pc & 32'hFFFF_FFFC;
        head_valid = (fifo_count != '0);
        // Gated by reset so no request escapes while memory is also in reset
        imem_req_valid = reset && !redirect_valid && credit_ok;
        imem_req_addr  = fetch_pc;
        req_fire   = imem_req_valid && imem_req_ready;
        drop       = imem_resp_valid && (drop_cnt != '0);
        push       = imem_resp_valid && !drop && !redirect_valid;
        pop        = head_valid && !stall && !redirect_valid;
        if_id_valid       = head_valid;
        if_id_pc          = head_valid ? fifo_pc[rd_ptr]  : hold_pc;
        if_id_instruction = head_valid ? fifo_ins[rd_ptr] : hold_ins;
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            fifo_pc[wr_ptr]  <= resp_pc;
            fifo_ins[wr_ptr] <= imem_resp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            hold_pc     <= '0;
            hold_ins    <= '0;
        end else begin
            if (head_valid) begin
                hold_pc  <= fifo_pc[rd_ptr];
                hold_ins <= fifo_ins[rd_ptr];
            end
            if (redirect_valid) begin
                // Everything still in flight belongs to the old path
                fetch_pc    <= target_pc;
                resp_pc     <= target_pc;
                outstanding <= outstanding - CNT_W'(imem_resp_valid);
                drop_cnt    <= outstanding - CNT_W'(imem_resp_valid);
                fifo_count  <= '0;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
            end else begin
                outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (drop) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
                if (push) begin
                    wr_ptr  <= ptr_inc(wr_ptr);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

endmodule
`default_nettype wire
